// File: rtl/mat_result_serializer.sv
// Streams one captured result matrix out as row-major beats with row/col tags,
// a last flag and a completed-frame counter; back-to-back frames run bubble-free.
module mat_result_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS_A     = 2,
  parameter int COLS_B     = 2,
  localparam int N  = ROWS_A * COLS_B,
  localparam int RW = (ROWS_A > 1) ? $clog2(ROWS_A) : 1,
  localparam int CW = (COLS_B > 1) ? $clog2(COLS_B) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*DATA_WIDTH-1:0] c,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [RW-1:0]         m_row,
  output logic [CW-1:0]         m_col,
  output logic [31:0]           frame_cnt,
  output logic                  state_dbg
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS_B - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a stalled beat holds its data.
  state_t                  state_q, state_d;
  logic [N*DATA_WIDTH-1:0] frame_q;
  logic [IW-1:0]           idx_q;
  logic                    beat;
  logic                    capture;

  assign m_valid   = (state_q == SEND);
  assign beat      = m_valid & m_ready;
  assign in_ready  = ~rst & ((state_q == IDLE) | (beat & m_last));
  assign capture   = in_valid & in_ready;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture) state_d = SEND;
      SEND:    if (beat && m_last && !capture) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // frame_q holds the elements not yet presented; element 0 sits in the MSBs,
  // so each accepted beat shifts the next element to the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q   <= '0;
      idx_q     <= '0;
      m_data    <= '0;
      m_last    <= 1'b0;
      m_row     <= '0;
      m_col     <= '0;
      frame_cnt <= '0;
    end else begin
      if (beat && m_last) frame_cnt <= frame_cnt + 32'd1;
      if (capture) begin
        m_data  <= c[N*DATA_WIDTH-1 -: DATA_WIDTH];
        frame_q <= c << DATA_WIDTH;
        idx_q   <= '0;
        m_last  <= (N == 1);
        m_row   <= '0;
        m_col   <= '0;
      end else if (beat && !m_last) begin
        m_data  <= frame_q[N*DATA_WIDTH-1 -: DATA_WIDTH];
        frame_q <= frame_q << DATA_WIDTH;
        idx_q   <= idx_q + IW'(1);
        m_last  <= ((idx_q + IW'(1)) == LAST_IDX);
        if (m_col == COL_MAX) begin
          m_col <= '0;
          m_row <= m_row + RW'(1);
        end else begin
          m_col <= m_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Scoreboard bench for mat_result_serializer: expected beats are queued at each
// capture handshake and compared when the stream hands a beat to the sink.
module tb_mat_result_serializer;

  localparam int DW = 8;
  localparam int RA = 2;
  localparam int CB = 2;
  localparam int N  = RA * CB;
  localparam int W  = DW + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] c;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic [0:0]      m_row;
  logic [0:0]      m_col;
  logic [31:0]     frame_cnt;
  logic            state_dbg;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int beat_cnt = 0;
  int rdy_cnt  = 0;
  bit cnt_rdy  = 0;
  bit stall_prev = 0;
  logic [W-1:0] held;

  mat_result_serializer #(.DATA_WIDTH(DW), .ROWS_A(RA), .COLS_B(CB)) dut (
    .clk(clk), .rst(rst), .c(c), .in_valid(in_valid), .in_ready(in_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_row(m_row), .m_col(m_col), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [N*DW-1:0] f);
    for (int r = 0; r < RA; r++) begin
      for (int k = 0; k < CB; k++) begin
        int e;
        logic [DW-1:0] el;
        logic [0:0] rr, kk;
        e  = r * CB + k;
        el = f[(N-1-e)*DW +: DW];
        rr = 1'(r);
        kk = 1'(k);
        exp_q.push_back({el, rr, kk, (e == N - 1)});
      end
    end
  endtask

  // scoreboard monitor, sampling mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] e;
    cur = {m_data, m_row, m_col, m_last};
    if (rst) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) check("stall_hold", 64'(cur), 64'(held));
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(cur), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(cur), 64'(e));
        end
      end
      if (in_valid && in_ready) push_frame(c);
      stall_prev = m_valid && !m_ready;
      held = cur;
    end
  end

  // driver tasks
  task automatic tick();
    #1;
    if (cnt_rdy) rdy_cnt += int'(in_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input bit rand_ready, output int cyc);
    cyc = 0;
    while ((m_valid || exp_q.size() != 0) && cyc < 200) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check("drain_timeout", 64'(cyc >= 200), 64'd0);
  endtask

  task automatic send_one(input logic [N*DW-1:0] f);
    c = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int b0;
    logic [7:0] pat [7];
    rst = 1'b1; in_valid = 1'b0; m_ready = 1'b0; c = '0;
    tick();
    tick();
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_m_row", 64'(m_row), 64'd0);
    check("rst_m_col", 64'(m_col), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_in_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready_high", 64'(in_ready), 64'd1);

    // reset then stream
    m_ready = 1'b1;
    b0 = beat_cnt;
    send_one(32'h1E2C3757);
    wait_drain(0, cyc);
    check("stream_cycles", 64'(cyc), 64'd4);
    check("stream_beats", 64'(beat_cnt - b0), 64'd4);
    check("stream_frame_cnt", 64'(frame_cnt), 64'd1);
    check("stream_in_ready", 64'(in_ready), 64'd1);

    // backpressure
    pat = '{8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
    b0 = beat_cnt;
    m_ready = 1'b0;
    send_one(32'h1E2C3757);
    for (int i = 0; i < 7; i++) begin
      m_ready = pat[i][0];
      tick();
    end
    m_ready = 1'b1;
    wait_drain(0, cyc);
    check("bp_beats", 64'(beat_cnt - b0), 64'd4);
    check("bp_frame_cnt", 64'(frame_cnt), 64'd2);

    // back-to-back frames
    b0 = beat_cnt;
    rdy_cnt = 0;
    cnt_rdy = 1;
    c = 32'h1E2C3757; in_valid = 1'b1; m_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 32'h0;
    tick(); tick(); tick();
    c = 32'h01020304; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt_rdy = 0;
    wait_drain(0, cyc);
    check("b2b_tail_cycles", 64'(cyc), 64'd4);
    check("b2b_beats", 64'(beat_cnt - b0), 64'd8);
    check("b2b_in_ready_pulses", 64'(rdy_cnt), 64'd2);
    check("b2b_frame_cnt", 64'(frame_cnt), 64'd4);

    // input isolation
    send_one(32'h1E2C3757);
    c = 32'hFFFF_FFFF;
    wait_drain(0, cyc);
    check("iso_frame_cnt", 64'(frame_cnt), 64'd5);

    // reset mid-frame
    send_one(32'h1E2C3757);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    b0 = beat_cnt;
    send_one(32'h05060708);
    wait_drain(0, cyc);
    check("midrst_new_beats", 64'(beat_cnt - b0), 64'd4);
    check("midrst_new_frame_cnt", 64'(frame_cnt), 64'd1);

    // counter wrap
    @(negedge clk);
    force dut.frame_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.frame_cnt;
    @(posedge clk);
    #1;
    check("wrap_preload", 64'(frame_cnt), 64'hFFFF_FFFF);
    send_one(32'hA1B2C3D4);
    wait_drain(0, cyc);
    check("wrap_frame_cnt", 64'(frame_cnt), 64'd0);

    // random frames with random sink stalls
    for (int f = 0; f < 6; f++) begin
      bit got;
      int guard;
      got = 0;
      guard = 0;
      c = $urandom;
      in_valid = 1'b1;
      while (!got && guard < 100) begin
        m_ready = 1'($urandom_range(0, 1));
        #1;
        got = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      check("rand_capture_timeout", 64'(got), 64'd1);
      in_valid = 1'b0;
      c = $urandom;
    end
    wait_drain(1, cyc);
    m_ready = 1'b1;
    wait_drain(0, cyc);
    check("rand_frame_cnt", 64'(frame_cnt), 64'd6);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
